round_controller: RTL and testbench

//  Game-round sequencer downstream of the player2 guess stage. Consumes player2's
//  per-symbol result and code-match flag, runs the round FSM (idle, player1 entry,

---
 rtl/round_controller_pkg.sv | 21 ++
 rtl/round_controller_sec_timer.sv | 40 ++++
 rtl/round_controller.sv | 104 ++++++++++
 tb/tb_round_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_controller_pkg.sv
// Shared game definitions: round FSM state codes, morse symbol codes and a saturating increment.
package round_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_WIN  = 3'd3,
        S_LOSE = 3'd4
    } state_t;

    // Symbol encodings shared with the player1/player2 entry stages.
    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_LINE = 2'b10;

    function automatic logic [6:0] sat_inc7(input logic [6:0] value, input logic [6:0] max);
        return (value >= max) ? max : value + 7'd1;
    endfunction

endpackage

// File: rtl/round_controller_sec_timer.sv
// Round countdown: prescaler divides clock to seconds, secs counts down to zero.
// Load takes one cycle; no backpressure, the timer simply freezes while run is low.
module round_controller_sec_timer #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic       run,
    input  logic [6:0] load_value,
    output logic [6:0] secs,
    output logic       expired
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] prescaler;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            prescaler <= '0;
            secs      <= '0;
        end else if (load) begin
            prescaler <= '0;
            secs      <= load_value;
        end else if (run) begin
            if (prescaler == PRESC_LAST) begin
                prescaler <= '0;
                if (secs != 7'd0)
                    secs <= secs - 7'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    assign expired = (secs == 7'd0);

endmodule

// File: rtl/round_controller.sv
// Round sequencer: idle -> player1 entry -> player2 guessing -> win/lose, with timeout, strikes and score.
// All outputs registered or decoded from registered state; inputs are levels/pulses, no backpressure.
module round_controller
    import round_controller_pkg::*;
#(
    parameter int CLK_PER_SEC   = 50_000_000,
    parameter int ROUND_SECONDS = 30,
    parameter int MAX_STRIKES   = 3,
    parameter int SCORE_MAX     = 99
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       p1_done,
    input  logic       p2_symbol,
    input  logic       p2_correct,
    input  logic       p2_complete,
    output logic       p1_enable,
    output logic       p2_resetn,
    output logic [2:0] state,
    output logic [6:0] time_left,
    output logic [2:0] strikes,
    output logic [6:0] score,
    output logic       win,
    output logic       lose
);

    state_t     cur_state;
    state_t     nxt_state;
    logic       sym_d;
    logic [2:0] strike_cnt;
    logic [6:0] score_q;
    logic       enter_p2;
    logic       in_p2;
    logic       strike_hit;
    logic       strike_out;
    logic       timer_expired;
    logic [6:0] secs;

    assign in_p2    = (cur_state == S_P2);
    assign enter_p2 = (cur_state == S_P1) && p1_done;

    // A strike coinciding with a code match is dropped: the win takes precedence.
    assign strike_hit = in_p2 && sym_d && !p2_correct && !p2_complete;
    assign strike_out = strike_hit && (({1'b0, strike_cnt} + 4'd1) >= 4'(MAX_STRIKES));

    round_controller_sec_timer #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_sec_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load       (enter_p2),
        .run        (in_p2),
        .load_value (7'(ROUND_SECONDS)),
        .secs       (secs),
        .expired    (timer_expired)
    );

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:  if (start) nxt_state = S_P1;
            S_P1:    if (p1_done) nxt_state = S_P2;
            S_P2: begin
                if (p2_complete)
                    nxt_state = S_WIN;
                else if (strike_out)
                    nxt_state = S_LOSE;
                else if (timer_expired)
                    nxt_state = S_LOSE;
            end
            S_WIN, S_LOSE: if (start) nxt_state = S_P1;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur_state  <= S_IDLE;
            sym_d      <= 1'b0;
            strike_cnt <= '0;
            score_q    <= '0;
        end else begin
            cur_state <= nxt_state;
            sym_d     <= p2_symbol && in_p2;
            if (enter_p2)
                strike_cnt <= '0;
            else if (strike_hit)
                strike_cnt <= strike_cnt + 3'd1;
            if (in_p2 && p2_complete)
                score_q <= sat_inc7(score_q, 7'(SCORE_MAX));
        end
    end

    assign state     = cur_state;
    assign p1_enable = (cur_state == S_P1);
    assign p2_resetn = in_p2;
    assign win       = (cur_state == S_WIN);
    assign lose      = (cur_state == S_LOSE);
    assign time_left = secs;
    assign strikes   = strike_cnt;
    assign score     = score_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with a fast timer (4 cycles/s, 3 s rounds, 2 strikes).
module tb_round_controller;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       p1_done;
    logic       p2_symbol;
    logic       p2_correct;
    logic       p2_complete;
    logic       p1_enable;
    logic       p2_resetn;
    logic [2:0] state;
    logic [6:0] time_left;
    logic [2:0] strikes;
    logic [6:0] score;
    logic       win;
    logic       lose;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int ST_IDLE = 0, ST_P1 = 1, ST_P2 = 2, ST_WIN = 3, ST_LOSE = 4;

    round_controller #(
        .CLK_PER_SEC  (4),
        .ROUND_SECONDS(3),
        .MAX_STRIKES  (2),
        .SCORE_MAX    (99)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .p1_done    (p1_done),
        .p2_symbol  (p2_symbol),
        .p2_correct (p2_correct),
        .p2_complete(p2_complete),
        .p1_enable  (p1_enable),
        .p2_resetn  (p2_resetn),
        .state      (state),
        .time_left  (time_left),
        .strikes    (strikes),
        .score      (score),
        .win        (win),
        .lose       (lose)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // IDLE/WIN/LOSE -> P1 -> P2, leaving all inputs low afterwards.
    task automatic begin_round();
        start = 1'b1;
        tick(1);
        start   = 1'b0;
        p1_done = 1'b1;
        tick(1);
        p1_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        p1_done     = 1'b0;
        p2_symbol   = 1'b0;
        p2_correct  = 1'b0;
        p2_complete = 1'b0;
        tick(2);

        chk("rst_state", state, ST_IDLE);
        chk("rst_time", time_left, 0);
        chk("rst_strikes", strikes, 0);
        chk("rst_score", score, 0);
        chk("rst_p1en", p1_enable, 0);
        chk("rst_p2rstn", p2_resetn, 0);
        chk("rst_winlose", {win, lose}, 0);

        // 1: full winning round
        resetn = 1'b1;
        start  = 1'b1;
        tick(1);
        chk("t1_p1", state, ST_P1);
        chk("t1_p1en", p1_enable, 1);
        start   = 1'b0;
        p1_done = 1'b1;
        tick(1);
        p1_done = 1'b0;
        chk("t1_p2", state, ST_P2);
        chk("t1_load", time_left, 3);
        chk("t1_p2rstn", p2_resetn, 1);
        chk("t1_p1en_off", p1_enable, 0);
        tick(5);
        chk("t1_time5", time_left, 2);
        p2_complete = 1'b1;
        tick(1);
        p2_complete = 1'b0;
        chk("t1_win", state, ST_WIN);
        chk("t1_winflag", win, 1);
        chk("t1_score", score, 1);
        chk("t1_p2rstn_off", p2_resetn, 0);
        tick(1);
        chk("t1_score_once", score, 1);
        chk("t1_time_hold", time_left, 2);

        // 2: timeout
        begin_round();
        chk("t2_load", time_left, 3);
        for (int k = 2; k >= 0; k--) begin
            tick(3);
            chk("t2_before_step", time_left, k + 1);
            tick(1);
            chk("t2_step", time_left, k);
            chk("t2_in_p2", state, ST_P2);
        end
        tick(1);
        chk("t2_lose", state, ST_LOSE);
        chk("t2_loseflag", lose, 1);
        chk("t2_score", score, 1);
        chk("t2_time_hold", time_left, 0);

        // 3: strikes
        begin_round();
        chk("t3_strk0", strikes, 0);
        p2_symbol = 1'b1;
        tick(1);
        p2_symbol  = 1'b0;
        p2_correct = 1'b1;
        tick(1);
        p2_correct = 1'b0;
        tick(1);
        chk("t3_correct_nostrike", strikes, 0);
        p2_symbol = 1'b1;
        tick(1);
        p2_symbol = 1'b0;
        tick(1);
        chk("t3_strk1", strikes, 1);
        chk("t3_still_p2", state, ST_P2);
        p2_symbol = 1'b1;
        tick(1);
        p2_symbol = 1'b0;
        tick(1);
        chk("t3_strk2", strikes, 2);
        chk("t3_lose", state, ST_LOSE);
        tick(1);
        chk("t3_strk_hold", strikes, 2);
        chk("t3_score", score, 1);

        // 4a: match on the cycle time_left reaches 0
        begin_round();
        tick(12);
        chk("t4_time0", time_left, 0);
        chk("t4_time0_p2", state, ST_P2);
        p2_complete = 1'b1;
        tick(1);
        p2_complete = 1'b0;
        chk("t4_timeout_win", state, ST_WIN);
        chk("t4_score_a", score, 2);

        // 4b: match on the cycle of a strike-out
        begin_round();
        p2_symbol = 1'b1;
        tick(1);
        p2_symbol = 1'b0;
        tick(1);
        chk("t4_strk1", strikes, 1);
        p2_symbol = 1'b1;
        tick(1);
        p2_symbol   = 1'b0;
        p2_complete = 1'b1;
        tick(1);
        p2_complete = 1'b0;
        chk("t4_strikeout_win", state, ST_WIN);
        chk("t4_strk_not_counted", strikes, 1);
        chk("t4_score_b", score, 3);

        // 6: ignored inputs in IDLE and P1_ENTRY
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        chk("t6_idle", state, ST_IDLE);
        p2_complete = 1'b1;
        tick(1);
        p2_complete = 1'b0;
        chk("t6_idle_p2c", state, ST_IDLE);
        chk("t6_idle_score", score, 0);
        p1_done = 1'b1;
        tick(1);
        p1_done = 1'b0;
        chk("t6_idle_p1d", state, ST_IDLE);
        start = 1'b1;
        tick(1);
        chk("t6_p1", state, ST_P1);
        p2_complete = 1'b1;
        tick(2);
        p2_complete = 1'b0;
        chk("t6_p1_hold", state, ST_P1);
        chk("t6_p1_score", score, 0);
        start     = 1'b0;
        p1_done   = 1'b1;
        p2_symbol = 1'b1;
        tick(1);
        p1_done   = 1'b0;
        p2_symbol = 1'b0;
        chk("t6_p2", state, ST_P2);
        tick(1);
        chk("t6_p1_symbol_ignored", strikes, 0);

        // 5: score saturation
        p2_complete = 1'b1;
        tick(1);
        p2_complete = 1'b0;
        chk("t5_first", score, 1);
        for (int r = 2; r <= 100; r++) begin
            begin_round();
            p2_complete = 1'b1;
            tick(1);
            p2_complete = 1'b0;
            if (r == 99) chk("t5_score99", score, 99);
        end
        chk("t5_saturated", score, 99);
        chk("t5_win", state, ST_WIN);

        // start held in WIN begins exactly one round
        start = 1'b1;
        tick(3);
        chk("t5_start_held", state, ST_P1);
        start   = 1'b0;
        p1_done = 1'b1;
        tick(1);
        p1_done = 1'b0;
        chk("t5_p2", state, ST_P2);
        tick(2);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        chk("t5_rst_state", state, ST_IDLE);
        chk("t5_rst_score", score, 0);
        chk("t5_rst_p2rstn", p2_resetn, 0);
        chk("t5_rst_time", time_left, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
